// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// wb_regfile_pkg
//   Shared register-file definitions used by the write-back stage and its
//   read ports.
//     REG_W        data width of one architectural register (RegBus)
//     REG_ADDR_W   register address width (RegAddrBus)
//     REG_NUM      number of architectural registers (RegNum)
//     REG_NUM_LOG2 log2 of REG_NUM (RegNumLog2)
//     ZERO_WORD    all-zero data word (ZeroWord)
//   Types: reg_bus_t, reg_addr_t, wb_entry_t (the WB pipeline register).
//   Helper: addr_hit() -- qualified address match used by the bypass muxes.
// -----------------------------------------------------------------------------
package wb_regfile_pkg;

  localparam int REG_W        = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int REG_NUM      = 32;
  localparam int REG_NUM_LOG2 = 5;

  typedef logic [REG_W-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_bus_t  ZERO_WORD = '0;
  localparam reg_addr_t ZERO_ADDR = '0;

  // Contents of the WB pipeline register: one pending write.
  typedef struct packed {
    logic      we;
    reg_addr_t waddr;
    reg_bus_t  wdata;
  } wb_entry_t;

  // True when a valid write targets the given read address.
  function automatic logic addr_hit(input logic      valid,
                                    input reg_addr_t waddr,
                                    input reg_addr_t raddr);
    return valid && (waddr == raddr);
  endfunction

endpackage

// File: rtl/wb_regfile_rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
//   One combinational register-file read port. Applies the enable and x0
//   masking, then selects between the EX result, the pending WB write and the
//   array word already looked up by the parent.
//
//   Build option: WB_REGFILE_BYPASS_EN
//     defined   : priority EX input > WB register > array; EX forwarding is
//                 blocked while flush is high (that result is being dropped).
//     undefined : array only; the decoder must stall on RAW hazards.
//
//   Ports
//     re, raddr       read enable / address from ID
//     arr_rdata       regs[raddr] from the parent array
//     ex_we/_waddr/_wdata  write presented by EX this cycle
//     flush           EX result of this cycle is being discarded
//     wb_we/_waddr/_wdata  write held in the WB register
//     rdata           read result (combinational)
// -----------------------------------------------------------------------------
module rf_read_port
  import wb_regfile_pkg::*;
(
  input  logic      re,
  input  reg_addr_t raddr,
  input  reg_bus_t  arr_rdata,
  input  logic      ex_we,
  input  reg_addr_t ex_waddr,
  input  reg_bus_t  ex_wdata,
  input  logic      flush,
  input  logic      wb_we,
  input  reg_addr_t wb_waddr,
  input  reg_bus_t  wb_wdata,
  output reg_bus_t  rdata
);

  always_comb begin
    rdata = ZERO_WORD;
    if (re && (raddr != ZERO_ADDR)) begin
`ifdef WB_REGFILE_BYPASS_EN
      if (addr_hit(ex_we && !flush, ex_waddr, raddr)) begin
        rdata = ex_wdata;
      end else if (addr_hit(wb_we, wb_waddr, raddr)) begin
        rdata = wb_wdata;
      end else begin
        rdata = arr_rdata;
      end
`else
      rdata = arr_rdata;
`endif
    end
  end

`ifndef WB_REGFILE_BYPASS_EN
  // Bypass inputs stay on the port list so the parent wiring is identical in
  // both builds; they are simply not consumed here.
  logic unused_bypass;
  assign unused_bypass = ^{ex_we, ex_waddr, ex_wdata, flush,
                           wb_we, wb_waddr, wb_wdata};
`endif

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Write-back end of the EX result interface. Captures the EX write into the
//   WB pipeline register, commits it to a 32x32 register file on the next
//   edge, and serves two combinational read ports to ID.
//
//   Build option: WB_REGFILE_BYPASS_EN enables read-after-write forwarding
//   from the EX input and the WB register (see rf_read_port).
//
//   Parameters
//     NREGS   number of architectural registers (32)
//     CNT_W   width of the retire counter
//
//   Ports
//     clk                rising-edge clock
//     rst                synchronous, active-high reset
//     stall              hold WB register and suppress commit this cycle
//     flush              drop the EX result being captured this cycle
//     we_i/waddr_i/wdata_i   EX write
//     re1/raddr1/rdata1  read port 1
//     re2/raddr2/rdata2  read port 2
//     wb_we_o/wb_waddr_o/wb_wdata_o  WB register contents
//     retire_cnt         committed writes to x1..x31 (wraps)
// -----------------------------------------------------------------------------
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NREGS = REG_NUM,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic             re1,
  input  logic [4:0]       raddr1,
  output logic [31:0]      rdata1,
  input  logic             re2,
  input  logic [4:0]       raddr2,
  output logic [31:0]      rdata2,
  output logic             wb_we_o,
  output logic [4:0]       wb_waddr_o,
  output logic [31:0]      wb_wdata_o,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [31:0] regs [0:NREGS-1];
  wb_entry_t   wb_q;
  logic        commit;

  // x0 writes travel through the WB register but never reach the array.
  assign commit = !stall && wb_q.we && (wb_q.waddr != ZERO_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q       <= '0;
      retire_cnt <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= ZERO_WORD;
      end
    end else if (!stall) begin
      if (commit) begin
        regs[wb_q.waddr] <= wb_q.wdata;
        retire_cnt       <= retire_cnt + CNT_W'(1);
      end
      // stall wins over flush: flush is only looked at when we capture.
      wb_q.we    <= we_i & ~flush;
      wb_q.waddr <= waddr_i;
      wb_q.wdata <= wdata_i;
    end
  end

  assign wb_we_o    = wb_q.we;
  assign wb_waddr_o = wb_q.waddr;
  assign wb_wdata_o = wb_q.wdata;

  rf_read_port u_rd1 (
    .re        (re1),
    .raddr     (raddr1),
    .arr_rdata (regs[raddr1]),
    .ex_we     (we_i),
    .ex_waddr  (waddr_i),
    .ex_wdata  (wdata_i),
    .flush     (flush),
    .wb_we     (wb_q.we),
    .wb_waddr  (wb_q.waddr),
    .wb_wdata  (wb_q.wdata),
    .rdata     (rdata1)
  );

  rf_read_port u_rd2 (
    .re        (re2),
    .raddr     (raddr2),
    .arr_rdata (regs[raddr2]),
    .ex_we     (we_i),
    .ex_waddr  (waddr_i),
    .ex_wdata  (wdata_i),
    .flush     (flush),
    .wb_we     (wb_q.we),
    .wb_waddr  (wb_q.waddr),
    .wb_wdata  (wb_q.wdata),
    .rdata     (rdata2)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//   Directed bench for wb_regfile. Expected values are pushed to a scoreboard
//   queue when the stimulus is driven and popped when the DUT output is
//   sampled. Expectations follow WB_REGFILE_BYPASS_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, flush, we_i, re1, re2;
  logic [4:0]  waddr_i, raddr1, raddr2, wb_waddr_o;
  logic [31:0] wdata_i, rdata1, rdata2, wb_wdata_o, retire_cnt;
  logic        wb_we_o;

  int passed = 0;
  int total  = 0;
  logic [31:0] expq[$];

  wb_regfile #(.NREGS(32), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .we_i       (we_i),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .re1        (re1),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .re2        (re2),
    .raddr2     (raddr2),
    .rdata2     (rdata2),
    .wb_we_o    (wb_we_o),
    .wb_waddr_o (wb_waddr_o),
    .wb_wdata_o (wb_wdata_o),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp(input logic [31:0] v);
    expq.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (expq.size() == 0) begin
      $error("FAIL %s: observed=%h but scoreboard empty", tag, obs);
    end else begin
      e = expq.pop_front();
      assert (obs === e) passed++;
      else $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    tick();
    rst = 1'b0;

    // 1: reset state
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd31;
    exp(0); exp(0); exp(0); exp(0);
    #1;
    chk("rst_rd_x5", rdata1);
    chk("rst_rd_x31", rdata2);
    chk("rst_wb_we", {31'b0, wb_we_o});
    chk("rst_cnt", retire_cnt);

    // 2: single write to x5, visible through bypass then array
    we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'hDEADBEEF;
    exp(BYP ? 32'hDEADBEEF : 32'h0);
    #1;
    chk("t2_ex_fwd", rdata1);
    exp(BYP ? 32'hDEADBEEF : 32'h0); exp(1); exp(5);
    tick();
    we_i = 1'b0;
    #1;
    chk("t2_wb_fwd", rdata1);
    chk("t2_wb_we", {31'b0, wb_we_o});
    chk("t2_wb_waddr", {27'b0, wb_waddr_o});
    exp(32'hDEADBEEF); exp(1); exp(0);
    tick();
    chk("t2_arr", rdata1);
    chk("t2_cnt", retire_cnt);
    chk("t2_wb_we_clr", {31'b0, wb_we_o});

    // 3: write to x0 is captured but never committed or counted
    we_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'h1234; raddr1 = 5'd0;
    exp(0);
    #1;
    chk("t3_rd_x0_ex", rdata1);
    exp(0); exp(1); exp(0);
    tick();
    we_i = 1'b0;
    #1;
    chk("t3_rd_x0_wb", rdata1);
    chk("t3_wb_we", {31'b0, wb_we_o});
    chk("t3_wb_waddr", {27'b0, wb_waddr_o});
    exp(0); exp(1); exp(0);
    tick();
    chk("t3_wb_we_clr", {31'b0, wb_we_o});
    chk("t3_cnt", retire_cnt);
    chk("t3_rd_x0_arr", rdata1);

    // 4: back-to-back writes to x7, younger wins
    we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'd1; raddr1 = 5'd7; raddr2 = 5'd7;
    tick();
    wdata_i = 32'd2;
    exp(BYP ? 32'd2 : 32'd0); exp(BYP ? 32'd2 : 32'd0);
    #1;
    chk("t4_p1_ex_over_wb", rdata1);
    chk("t4_p2_ex_over_wb", rdata2);
    exp(BYP ? 32'd2 : 32'd1); exp(2);
    tick();
    we_i = 1'b0;
    #1;
    chk("t4_wb_over_arr", rdata1);
    chk("t4_cnt_mid", retire_cnt);
    exp(2); exp(2); exp(3);
    tick();
    chk("t4_arr_p1", rdata1);
    chk("t4_arr_p2", rdata2);
    chk("t4_cnt", retire_cnt);

    // 5: stall holds the WB register; EX activity during stall is ignored
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'hA5; raddr1 = 5'd9; re2 = 1'b0;
    tick();
    stall = 1'b1;
    waddr_i = 5'd10; wdata_i = 32'hBAD;
    for (int k = 0; k < 3; k++) begin
      exp(1); exp(9); exp(32'hA5); exp(3); exp(BYP ? 32'hA5 : 32'h0); exp(0);
      tick();
      chk("t5_hold_we", {31'b0, wb_we_o});
      chk("t5_hold_waddr", {27'b0, wb_waddr_o});
      chk("t5_hold_wdata", wb_wdata_o);
      chk("t5_hold_cnt", retire_cnt);
      chk("t5_hold_rd_x9", rdata1);
      chk("t5_re2_off", rdata2);
    end
    stall = 1'b0; we_i = 1'b0;
    exp(4); exp(32'hA5); exp(0);
    tick();
    chk("t5_cnt_after", retire_cnt);
    chk("t5_arr_x9", rdata1);
    chk("t5_wb_we_clr", {31'b0, wb_we_o});

    // 6: flush drops the EX write and blocks its forwarding
    we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h11;
    tick();
    we_i = 1'b0;
    tick();
    we_i = 1'b1; wdata_i = 32'h55; flush = 1'b1; raddr1 = 5'd3;
    exp(32'h11); exp(5);
    #1;
    chk("t6_no_fwd", rdata1);
    chk("t6_cnt_pre", retire_cnt);
    exp(0); exp(32'h11);
    tick();
    flush = 1'b0; we_i = 1'b0;
    #1;
    chk("t6_wb_we", {31'b0, wb_we_o});
    chk("t6_rd_x3", rdata1);
    exp(32'h11); exp(5);
    tick();
    chk("t6_arr_x3", rdata1);
    chk("t6_cnt", retire_cnt);

    // read enable low masks a live register
    re1 = 1'b0;
    exp(0);
    #1;
    chk("re_off", rdata1);

    // second reset clears the array and the counter
    re1 = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    exp(0); exp(0);
    #1;
    chk("rst2_arr_x3", rdata1);
    chk("rst2_cnt", retire_cnt);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
